tile_8_pixel_fetch: RTL and testbench
=====================================

TILE_8_PIXEL_FETCH -- requirements
Module: tile_8_pixel_fetch

Interface
REQ-001 The block SHALL have parameter TILE_W, default 64, giving the tile width in pixels; it SHALL be a power of two from 8 to 256.
REQ-002 The block SHALL have parameter TILE_H, default 64, giving the tile height in pixels; it SHALL be a power of two from 8 to 256.
REQ-003 Port vga_clk, input, 1 bit: pixel clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port drawX, input, 10 bits: current pixel column.
REQ-006 Port drawY, input, 10 bits: current pixel row.
REQ-007 Port de_in, input, 1 bit: display enable (1 = active video).
REQ-008 Ports hs_in and vs_in, input, 1 bit each: sync pulses, active-low.
REQ-009 Port tile_x, input, 10 bits: requested tile left edge.
REQ-010 Port tile_y, input, 10 bits: requested tile top edge.
REQ-011 Port rom_addr, output, log2(TILE_W*TILE_H) bits: tile ROM address.
REQ-012 Port rom_q, input, 5 bits: ROM data; it SHALL be valid exactly 1 cycle after rom_addr is registered.
REQ-013 Port index, output, 5 bits: palette index for the downstream palette lookup.
REQ-014 Port opaque, output, 1 bit: pixel is inside the tile and its index is not 0.
REQ-015 Ports de_out, hs_out and vs_out, output, 1 bit each: sync signals aligned with index.

Function
REQ-016 Active position registers pos_x/pos_y SHALL load tile_x/tile_y only on the cycle where vs_in changes from 1 to 0; otherwise they SHALL hold.
REQ-017 Stage 1 SHALL register hit = de_in AND drawX >= pos_x AND drawX < pos_x+TILE_W AND drawY >= pos_y AND drawY < pos_y+TILE_H.
REQ-018 Bounds arithmetic SHALL use 11 bits so that pos_x+TILE_W > 1023 does not wrap; the tile SHALL then be clipped at column/row 1023.
REQ-019 Stage 1 SHALL register rom_addr = {drawY-pos_y, drawX-pos_x}, truncated to log2(TILE_H) and log2(TILE_W) bits respectively.
REQ-020 When hit = 0, rom_addr SHALL hold its previous value, to avoid needless ROM toggling.
REQ-021 Stage 2 SHALL delay hit and the sync signals by one cycle while the ROM read completes.
REQ-022 Stage 3 SHALL register index = rom_q if the delayed hit = 1, else 0.
REQ-023 Stage 3 SHALL register opaque = delayed hit AND (rom_q != 0).
REQ-024 de_out, hs_out and vs_out SHALL equal de_in, hs_in and vs_in delayed exactly 3 cycles.
REQ-025 Total latency from drawX/drawY/de_in to index/opaque SHALL be exactly 3 cycles, with 1 pixel per cycle throughput and no stalls.
REQ-026 A tile_x/tile_y change mid-frame SHALL have no effect until the next vs_in falling edge.
REQ-027 If tile_x/tile_y change on the same cycle as the vs_in falling edge, the new values SHALL be loaded.
REQ-028 In a frame where the tile lies fully off-screen (pos_x or pos_y >= 640/480), opaque SHALL stay 0 throughout active video.

Reset
REQ-029 While reset_n = 0, the block SHALL force pos_x = 0, pos_y = 0, rom_addr = 0, index = 0, opaque = 0, de_out = 0, hs_out = 1, vs_out = 1, and clear all pipeline hit/sync stages to the same inactive values.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels with no partial output.
REQ-031 After reset release, pos_x/pos_y SHALL remain at 0 until the next vs_in falling edge.
REQ-032 After reset release, outputs SHALL become valid 3 cycles after the first sampled input.

Verification
REQ-033 Latch and latency: tile_x=100 and tile_y=50 applied with a vs_in falling edge, then drawX=100, drawY=50, de_in=1 -> rom_addr=0 one cycle later; with rom_q=7, index=7 and opaque=1 three cycles after input.
REQ-034 Transparency and edges: with the same position, drawX=163 (last column) and drawY=50 -> rom_addr=63; with rom_q=0, index=0 and opaque=0. drawX=164 -> index=0 and opaque=0 regardless of rom_q.
REQ-035 Mid-frame move: tile_x changed to 300 while vs_in=1 -> pixels at drawX=100 remain hits until the next vs_in fall; afterwards drawX=300 hits and drawX=100 does not.
REQ-036 Clipping: tile_x=1000 latched, drawX=1023 -> hit with rom_addr low bits=23; no hit at drawX=0 (no wrap).
REQ-037 Sync alignment: random de_in/hs_in/vs_in pattern -> outputs equal the inputs delayed 3 cycles bit-for-bit, and opaque is never 1 while de_out=0.
REQ-038 Reset mid-line: reset_n pulsed low for 2 cycles during a hit run -> outputs immediately take reset values, pos_x and pos_y read 0, and no stale index appears after release.

Source files
------------

// File: rtl/tile_8_pixel_fetch.sv
// Three-stage pixel fetch for one sprite tile: bounds test and ROM address,
// ROM read wait, then palette index / opacity with the sync signals aligned.
module tile_8_pixel_fetch #(
    parameter  int TILE_W = 64,
    parameter  int TILE_H = 64,
    localparam int XW     = $clog2(TILE_W),
    localparam int YW     = $clog2(TILE_H),
    localparam int AW     = XW + YW
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic [9:0]    drawX,
    input  logic [9:0]    drawY,
    input  logic          de_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic [9:0]    tile_x,
    input  logic [9:0]    tile_y,
    output logic [AW-1:0] rom_addr,
    input  logic [4:0]    rom_q,
    output logic [4:0]    index,
    output logic          opaque,
    output logic          de_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic [9:0]    pos_x_o,
    output logic [9:0]    pos_y_o
);

    logic [9:0]    pos_x_q, pos_x_d;
    logic [9:0]    pos_y_q, pos_y_d;
    logic          vs_prev_q;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          hit1_q, de1_q, hs1_q, vs1_q;
    logic          hit2_q, de2_q, hs2_q, vs2_q;
    logic [4:0]    index_q;
    logic          opaque_q, de3_q, hs3_q, vs3_q;

    logic          vs_fall;
    logic          hit_c;
    logic [10:0]   x_ext, y_ext, px_ext, py_ext, x_end, y_end;
    logic [9:0]    x_off, y_off;

    // 11-bit bounds so a tile hanging past column/row 1023 is clipped, not wrapped.
    always_comb begin
        vs_fall = vs_prev_q & ~vs_in;
        x_ext   = {1'b0, drawX};
        y_ext   = {1'b0, drawY};
        px_ext  = {1'b0, pos_x_q};
        py_ext  = {1'b0, pos_y_q};
        x_end   = px_ext + 11'(TILE_W);
        y_end   = py_ext + 11'(TILE_H);
        hit_c   = de_in & (x_ext >= px_ext) & (x_ext < x_end)
                        & (y_ext >= py_ext) & (y_ext < y_end);
        x_off   = drawX - pos_x_q;
        y_off   = drawY - pos_y_q;
    end

    always_comb begin
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        rom_addr_d = rom_addr_q;
        if (vs_fall) begin
            pos_x_d = tile_x;
            pos_y_d = tile_y;
        end
        // Address only moves on hits so the ROM stays quiet elsewhere.
        if (hit_c) begin
            rom_addr_d = {y_off[YW-1:0], x_off[XW-1:0]};
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            vs_prev_q  <= 1'b1;
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            de1_q      <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            hit2_q     <= 1'b0;
            de2_q      <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            index_q    <= '0;
            opaque_q   <= 1'b0;
            de3_q      <= 1'b0;
            hs3_q      <= 1'b1;
            vs3_q      <= 1'b1;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vs_prev_q  <= vs_in;
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit_c;
            de1_q      <= de_in;
            hs1_q      <= hs_in;
            vs1_q      <= vs_in;
            hit2_q     <= hit1_q;
            de2_q      <= de1_q;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            index_q    <= hit2_q ? rom_q : 5'd0;
            opaque_q   <= hit2_q & (rom_q != 5'd0);
            de3_q      <= de2_q;
            hs3_q      <= hs2_q;
            vs3_q      <= vs2_q;
        end
    end

    assign rom_addr = rom_addr_q;
    assign index    = index_q;
    assign opaque   = opaque_q;
    assign de_out   = de3_q;
    assign hs_out   = hs3_q;
    assign vs_out   = vs3_q;
    assign pos_x_o  = pos_x_q;
    assign pos_y_o  = pos_y_q;

endmodule

// File: tb/tb_tile_8_pixel_fetch.sv
// Randomized bench for tile_8_pixel_fetch with a per-pixel reference model
// and a 3-deep expected-output queue.
module tb_tile_8_pixel_fetch;

    localparam int TW = 64;
    localparam int TH = 64;
    localparam int AW = 12;

    // clock / reset
    logic vga_clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 vga_clk = ~vga_clk;

    logic [9:0]    drawX, drawY, tile_x, tile_y;
    logic          de_in, hs_in, vs_in;
    logic [AW-1:0] rom_addr;
    logic [4:0]    rom_q = '0;
    logic [4:0]    index;
    logic          opaque, de_out, hs_out, vs_out;
    logic [9:0]    pos_x_o, pos_y_o;

    tile_8_pixel_fetch #(.TILE_W(TW), .TILE_H(TH)) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .drawX   (drawX),
        .drawY   (drawY),
        .de_in   (de_in),
        .hs_in   (hs_in),
        .vs_in   (vs_in),
        .tile_x  (tile_x),
        .tile_y  (tile_y),
        .rom_addr(rom_addr),
        .rom_q   (rom_q),
        .index   (index),
        .opaque  (opaque),
        .de_out  (de_out),
        .hs_out  (hs_out),
        .vs_out  (vs_out),
        .pos_x_o (pos_x_o),
        .pos_y_o (pos_y_o)
    );

    // synchronous tile ROM: data one cycle after the address register
    logic [4:0] rom_mem [0:TW*TH-1];
    always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

    // scoreboard: {de, hs, vs, opaque, index}
    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int   m_px = 0, m_py = 0;
    logic m_prev_vs = 1'b1;
    int   addr_model = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        logic [8:0] e;
        check_val("rom_addr", 32'(rom_addr), 32'(addr_model));
        check_val("pos_x", 32'(pos_x_o), 32'(m_px));
        check_val("pos_y", 32'(pos_y_o), 32'(m_py));
        check_val("opaque_without_de", 32'(opaque & ~de_out), 32'd0);
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            check_val("de_out", 32'(de_out), 32'(e[8]));
            check_val("hs_out", 32'(hs_out), 32'(e[7]));
            check_val("vs_out", 32'(vs_out), 32'(e[6]));
            check_val("opaque", 32'(opaque), 32'(e[5]));
            check_val("index", 32'(index), 32'(e[4:0]));
        end
    endtask

    // one pixel clock: check what has emerged, then drive and predict
    task automatic step(input logic de, input logic hs, input logic vs,
                        input int x, input int y, input int tx, input int ty);
        logic       hit;
        logic [4:0] idx;
        @(negedge vga_clk);
        check_outputs();
        de_in  = de;
        hs_in  = hs;
        vs_in  = vs;
        drawX  = x[9:0];
        drawY  = y[9:0];
        tile_x = tx[9:0];
        tile_y = ty[9:0];
        hit = de && x >= m_px && x < m_px + TW && y >= m_py && y < m_py + TH;
        idx = 5'd0;
        if (hit) begin
            addr_model = (y - m_py) * TW + (x - m_px);
            idx = rom_mem[addr_model];
        end
        exp_q.push_back({de, hs, vs, (idx != 5'd0), idx});
        if (m_prev_vs && !vs) begin
            m_px = tx;
            m_py = ty;
        end
        m_prev_vs = vs;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_index"}, 32'(index), 32'd0);
        check_val({tag, "_opaque"}, 32'(opaque), 32'd0);
        check_val({tag, "_de"}, 32'(de_out), 32'd0);
        check_val({tag, "_hs"}, 32'(hs_out), 32'd1);
        check_val({tag, "_vs"}, 32'(vs_out), 32'd1);
        check_val({tag, "_addr"}, 32'(rom_addr), 32'd0);
        check_val({tag, "_pos_x"}, 32'(pos_x_o), 32'd0);
        check_val({tag, "_pos_y"}, 32'(pos_y_o), 32'd0);
    endtask

    // reset asserted shortly after a rising edge, released on a falling edge
    task automatic do_reset(input int cycles);
        @(posedge vga_clk);
        #2;
        reset_n = 1'b0;
        de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        drawX = '0; drawY = '0;
        #1;
        check_reset_values("rst_now");
        repeat (cycles) @(negedge vga_clk);
        check_reset_values("rst_hold");
        reset_n = 1'b1;
        exp_q.delete();
        repeat (3) exp_q.push_back(9'b0_1_1_0_00000);
        m_px = 0; m_py = 0; m_prev_vs = 1'b1; addr_model = 0;
    endtask

    task automatic latch_tile(input int tx, input int ty);
        step(0, 1, 1, 0, 0, tx, ty);
        step(0, 1, 0, 0, 0, tx, ty);
        step(0, 1, 1, 0, 0, tx, ty);
    endtask

    task automatic flush();
        repeat (4) step(0, 1, 1, 0, 0, 0, 0);
    endtask

    function automatic int clamp10(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx, ty, x, y;
        for (int i = 0; i < TW*TH; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rom_mem[0]  = 5'd7;
        rom_mem[63] = 5'd0;
        de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        drawX = '0; drawY = '0; tile_x = '0; tile_y = '0;

        do_reset(3);
        flush();

        // latch and latency, last column, first column outside
        latch_tile(100, 50);
        step(1, 1, 1, 100, 50, 0, 0);
        step(1, 1, 1, 163, 50, 0, 0);
        step(1, 1, 1, 164, 50, 0, 0);
        step(1, 1, 1, 101, 51, 0, 0);
        step(1, 1, 1, 99, 50, 0, 0);
        step(1, 1, 1, 163, 113, 0, 0);
        step(1, 1, 1, 100, 114, 0, 0);
        flush();

        // mid-frame move only takes effect at the next vs fall
        step(1, 1, 1, 100, 50, 300, 50);
        step(1, 1, 1, 100, 50, 300, 50);
        step(1, 1, 1, 300, 50, 300, 50);
        step(0, 1, 0, 0, 0, 300, 50);
        step(0, 1, 1, 0, 0, 300, 50);
        step(1, 1, 1, 300, 50, 0, 0);
        step(1, 1, 1, 100, 50, 0, 0);
        flush();

        // clipping at column 1023 without wrap
        latch_tile(1000, 50);
        step(1, 1, 1, 1023, 50, 0, 0);
        step(1, 1, 1, 0, 50, 0, 0);
        step(1, 1, 1, 1010, 60, 0, 0);
        step(1, 1, 1, 20, 60, 0, 0);
        flush();

        // fully off-screen tile
        latch_tile(700, 500);
        for (int i = 0; i < 40; i++)
            step(1, 1, 1, $urandom_range(0, 639), $urandom_range(0, 479), 0, 0);
        flush();

        // random sync/pixel traffic with occasional tile moves
        tx = 100; ty = 50;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                tx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 600);
                ty = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 440);
            end
            if ($urandom_range(0, 1) == 0) begin
                x = clamp10(m_px - 2 + $urandom_range(0, TW + 3));
                y = clamp10(m_py - 2 + $urandom_range(0, TH + 3));
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) != 0), x, y, tx, ty);
        end
        flush();

        // reset in the middle of a hit run
        latch_tile(100, 50);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 100 + i, 50, 0, 0);
        do_reset(2);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 100 + i, 50, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, i, 5, 0, 0);
        latch_tile(100, 50);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 100 + i, 52, 0, 0);
        flush();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
